// File: rtl/bitop_pipe.sv
// Operand pipeline: pass / XOR-accumulate / saturating-add / popcount, followed by
// STAGES elastic output registers with valid/ready handshaking on both sides.
module bitop_pipe #(
  parameter int unsigned IN_W   = 5,
  parameter int unsigned OUT_W  = 10,
  parameter int unsigned STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IN_W-1:0]   input_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        mode,
  input  logic              acc_clr,
  output logic [OUT_W-1:0]  output_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       count
);

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_XOR  = 2'd1,
    MODE_SAT  = 2'd2,
    MODE_POP  = 2'd3
  } mode_e;

  mode_e              mode_sel;
  logic [OUT_W-1:0]   acc_q, acc_d;
  logic [15:0]        count_q, count_d;
  logic [STAGES-1:0]  valid_q, valid_d, stage_rdy;
  logic [OUT_W-1:0]   data_q [STAGES];
  logic [OUT_W-1:0]   data_d [STAGES];
  logic               fire_in;
  logic               tail_full;
  logic [OUT_W-1:0]   x, base, pop, result;
  logic [OUT_W:0]     sum;

  // A stage can take new data unless it and every stage after it are full while
  // the sink stalls; written in closed form to avoid a combinational chain on itself.
  always_comb begin
    stage_rdy = '0;
    tail_full = 1'b1;
    for (int unsigned k = 0; k < STAGES; k++) begin
      tail_full = 1'b1;
      for (int unsigned j = 0; j < STAGES; j++) begin
        if (j >= k) tail_full = tail_full & valid_q[j];
      end
      stage_rdy[k] = out_ready | ~tail_full;
    end
  end

  assign in_ready = stage_rdy[0];
  assign fire_in  = in_valid & stage_rdy[0];
  assign mode_sel = mode_e'(mode);

  always_comb begin
    x    = OUT_W'(input_data);
    base = acc_clr ? '0 : acc_q;
    sum  = {1'b0, base} + {1'b0, x};
    pop  = '0;
    for (int unsigned i = 0; i < IN_W; i++) begin
      pop = pop + OUT_W'(input_data[i]);
    end
    case (mode_sel)
      MODE_PASS: result = x;
      MODE_XOR:  result = base ^ x;
      MODE_SAT:  result = sum[OUT_W] ? '1 : sum[OUT_W-1:0];
      default:   result = pop;
    endcase
  end

  always_comb begin
    acc_d   = base;
    count_d = acc_clr ? '0 : count_q;
    if (fire_in) begin
      count_d = count_d + 16'd1;
      if (mode_sel == MODE_XOR || mode_sel == MODE_SAT) acc_d = result;
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (stage_rdy[0]) begin
      valid_d[0] = fire_in;
      if (fire_in) data_d[0] = result;
    end
    for (int unsigned k = 1; k < STAGES; k++) begin
      if (stage_rdy[k]) begin
        valid_d[k] = valid_q[k-1];
        if (valid_q[k-1]) data_d[k] = data_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int unsigned k = 0; k < STAGES; k++) data_q[k] <= '0;
    end else begin
      acc_q   <= acc_d;
      count_q <= count_d;
      valid_q <= valid_d;
      for (int unsigned k = 0; k < STAGES; k++) data_q[k] <= data_d[k];
    end
  end

  assign output_data = data_q[STAGES-1];
  assign out_valid   = valid_q[STAGES-1];
  assign count       = count_q;

endmodule

// File: tb/tb_bitop_pipe.sv
// Directed and random stimulus for bitop_pipe, checked against a queue-based
// transaction model of the accumulator, counter and in-order result stream.
module tb_bitop_pipe;

  localparam int IN_W   = 5;
  localparam int OUT_W  = 10;
  localparam int STAGES = 2;
  localparam int SAT_MAX = (1 << OUT_W) - 1;

  logic              clk;
  logic              rst_n;
  logic [IN_W-1:0]   input_data;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        mode;
  logic              acc_clr;
  logic [OUT_W-1:0]  output_data;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       count;

  bitop_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .input_data(input_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .acc_clr(acc_clr), .output_data(output_data),
    .out_valid(out_valid), .out_ready(out_ready), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int m_acc = 0;
  int m_count = 0;
  int q[$];
  int qcyc[$];
  int cyc = 0;
  bit lat_chk = 0;
  bit prev_stall = 0;
  logic [OUT_W-1:0] prev_data = '0;
  int accepted;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check visible outputs, update the model, advance.
  task automatic step(input bit iv, input int d, input int md, input bit clr, input bit ordy);
    int base, res, expv, pc;
    bit pred_rdy;
    in_valid   = iv;
    input_data = d[IN_W-1:0];
    mode       = md[1:0];
    acc_clr    = clr;
    out_ready  = ordy;
    #1;
    pred_rdy = ordy || (q.size() < STAGES);
    check("in_ready", {31'd0, in_ready}, {31'd0, pred_rdy});
    check("count", {16'd0, count}, m_count);
    if (prev_stall) begin
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_data", {22'd0, output_data}, {22'd0, prev_data});
    end
    if (out_valid && ordy) begin
      if (q.size() == 0) begin
        check("spurious_out", {31'd0, out_valid}, 32'd0);
      end else begin
        expv = q.pop_front();
        pc = qcyc.pop_front();
        check("out_data", {22'd0, output_data}, expv);
        if (lat_chk) check("latency", cyc - pc, STAGES);
      end
    end
    prev_stall = out_valid && !ordy;
    prev_data  = output_data;
    base = clr ? 0 : m_acc;
    m_acc = base;
    m_count = clr ? 0 : m_count;
    if (iv && pred_rdy) begin
      case (md)
        0: res = d;
        1: res = base ^ d;
        2: begin res = base + d; if (res > SAT_MAX) res = SAT_MAX; end
        default: res = $countones(d[IN_W-1:0]);
      endcase
      if (md == 1 || md == 2) m_acc = res;
      m_count = (m_count + 1) % 65536;
      q.push_back(res);
      qcyc.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) step(0, 0, 0, 0, 1);
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 0; input_data = '0; mode = '0; acc_clr = 0; out_ready = 0;
    #3;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_count", {16'd0, count}, 32'd0);
    check("rst_out_data", {22'd0, output_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // streaming, latency STAGES
    lat_chk = 1;
    step(1, 1, 0, 0, 1);
    step(1, 2, 0, 0, 1);
    step(1, 3, 0, 0, 1);
    drain();
    lat_chk = 0;
    check("stream_count", {16'd0, count}, 32'd3);

    // XOR accumulate
    step(1, 'h1F, 1, 0, 1);
    step(1, 'h0A, 1, 0, 1);
    drain();

    // saturation
    step(0, 0, 0, 1, 1);
    for (int i = 0; i < 40; i++) step(1, 'h1F, 2, 0, 1);
    drain();

    // backpressure: only STAGES operands fit
    accepted = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; out_ready = 0; #1;
      accepted += in_ready;
      #0 step(1, 4 + i, 0, 0, 0);
    end
    check("bp_accepted", accepted, 2);
    drain();

    // clear/popcount collision
    step(1, 'h15, 1, 1, 1);
    step(1, 'h03, 2, 1, 1);
    check("clr_count", {16'd0, count}, 32'd1);
    step(1, 'h1B, 3, 0, 1);
    drain();

    // random traffic with mode changes during stalls
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 3),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
    end
    drain();

    // reset with two results in flight
    step(1, 7, 0, 0, 0);
    step(1, 9, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_count", {16'd0, count}, 32'd0);
    q.delete(); qcyc.delete();
    m_acc = 0; m_count = 0; prev_stall = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      out_ready = 1; in_valid = 0; #1;
      check("no_stale", {31'd0, out_valid}, 32'd0);
      step(0, 0, 0, 0, 1);
    end
    step(1, 'h11, 0, 0, 1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bitop_pipe.md
BITOP_PIPE -- requirements
Module: bitop_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 5, input operand width (1..16).
REQ-002 SHALL have parameter OUT_W, default 10, result width (must be >= IN_W+1).
REQ-003 SHALL have parameter STAGES, default 2, number of output register stages (1..4).
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port input_data, input, IN_W, operand.
REQ-007 SHALL have port in_valid, input, 1, operand valid.
REQ-008 SHALL have port in_ready, output, 1, block accepts operand this cycle.
REQ-009 SHALL have port mode, input, 2, operation select, sampled with the operand.
REQ-010 SHALL have port acc_clr, input, 1, synchronous accumulator clear.
REQ-011 SHALL have port output_data, output, OUT_W, result.
REQ-012 SHALL have port out_valid, output, 1, result valid.
REQ-013 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-014 SHALL have port count, output, 16, number of accepted operands since reset or clear.

Function
REQ-015 SHALL accept an operand when in_valid && in_ready (fire_in); results transfer when out_valid && out_ready (fire_out).
REQ-016 SHALL compute, with x = input_data zero-extended to OUT_W: mode 0 -> x; mode 1 -> acc ^ x; mode 2 -> min(acc + x, 2^OUT_W-1); mode 3 -> popcount(input_data) zero-extended.
REQ-017 SHALL hold a single OUT_W accumulator acc, written with the mode-1 or mode-2 result on each fire_in in those modes; modes 0 and 3 leave acc unchanged.
REQ-018 SHALL saturate mode 2 at all-ones; acc stays at all-ones on further adds, no wrap.
REQ-019 SHALL implement STAGES elastic register stages, each holding data plus a valid bit; a stage advances when the next stage is empty or advancing.
REQ-020 SHALL deliver a result STAGES cycles after fire_in when out_ready is held high (latency = STAGES).
REQ-021 SHALL drive in_ready high whenever stage 1 is empty or advancing in the same cycle; with out_ready high, throughput is one operand per cycle.
REQ-022 SHALL hold output_data and out_valid stable while out_valid && !out_ready.
REQ-023 SHALL never drop or duplicate a result; order of results equals order of acceptance.
REQ-024 SHALL, on acc_clr, set acc and count to 0 next cycle; if fire_in coincides, the operand is processed against acc = 0 and count becomes 1.
REQ-025 SHALL NOT affect results already in the pipeline when acc_clr asserts.
REQ-026 SHALL increment count by 1 on each fire_in, wrapping 0xFFFF -> 0x0000.
REQ-027 SHALL use mode only at fire_in; changing mode while stalled has no effect on queued results.

Reset
REQ-028 SHALL, while rst_n low, asynchronously force all stage valid bits to 0, acc to 0, count to 0, output_data to 0, out_valid to 0.
REQ-029 SHALL drive in_ready high from the first clock edge after rst_n deasserts.
REQ-030 SHALL discard all in-flight results on reset assertion mid-operation; no result emerges after reset for operands accepted before it.

Verification (IN_W=5, OUT_W=10, STAGES=2)
REQ-031 SHALL cover streaming: mode 0, operands 1,2,3 back-to-back, out_ready=1 -> out 1,2,3 on cycles 2,3,4 after first fire_in, count=3.
REQ-032 SHALL cover XOR accumulate: mode 1, operands 0x1F,0x0A -> outputs 0x01F,0x015; acc=0x015.
REQ-033 SHALL cover saturation: mode 2, 40 operands of 0x1F -> outputs rise by 31 until 0x3FF (cap at operand 34 onward), never wrap.
REQ-034 SHALL cover backpressure: out_ready=0 with 4 operands offered -> exactly 2 accepted, in_ready low, output held; release -> results in order, none lost.
REQ-035 SHALL cover clear/popcount collision: acc=0x015, acc_clr with mode 2 operand 0x03 -> output 0x003, count=1; mode 3 operand 0x1B -> output 0x004.
REQ-036 SHALL cover reset mid-stream: rst_n low with 2 results in flight -> out_valid=0, count=0 immediately; no stale result after release.
